pixel_point_op: RTL

//  Streaming per-channel pixel point-operation engine: offset with saturation, invert, binary threshold.

---
 rtl/pixel_point_op.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_point_op.sv
// Streaming per-channel point operation (offset/saturate, invert, threshold) with AXI4-Lite config.
// Define PIXEL_POINT_OP_STATS_EN to add the BEAT_CNT/FRAME_CNT handshake counters at 0x0C/0x10.
module pixel_point_op #(
    parameter int CH_WIDTH   = 8,
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         axi_clk,
    input  logic                         axi_reset,
    input  logic                         s_axis_valid,
    output logic                         s_axis_ready,
    input  logic                         s_axis_last,
    input  logic [CH_WIDTH*NUM_CH-1:0]   s_axis_data,
    input  logic [CH_WIDTH*NUM_CH/8-1:0] s_axis_keep,
    output logic                         m_axis_valid,
    input  logic                         m_axis_ready,
    output logic                         m_axis_last,
    output logic [CH_WIDTH*NUM_CH-1:0]   m_axis_data,
    output logic [CH_WIDTH*NUM_CH/8-1:0] m_axis_keep,
    input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [31:0]                  s_axi_wdata,
    input  logic [3:0]                   s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    output logic [1:0]                   s_axi_bresp,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [1:0]                   s_axi_rresp,
    output logic [31:0]                  s_axi_rdata
);

    localparam int DW = CH_WIDTH * NUM_CH;

    typedef enum logic [1:0] {IDLE, WRESP, RRESP} lite_state_t;

    lite_state_t          state, state_next;
    logic                 wr_fire, rd_fire;
    logic [2:0]           wr_idx, rd_idx;
    logic [31:0]          wmask, rd_val;

    logic [3:0]           ctrl_sh, ctrl_act, cfg_ctrl;
    logic [CH_WIDTH-1:0]  thresh_sh, thresh_act, cfg_thresh;
    logic [CH_WIDTH:0]    offset_sh, offset_act, cfg_offset;
    logic                 in_frame;

    logic                 s_fire, m_fire;
    logic [DW-1:0]        proc_data;

    // ------------------------------------------------------------------
    // Point operation on one channel; BYPASS overrides everything.
    // ------------------------------------------------------------------
    function automatic logic [CH_WIDTH-1:0] point_op(
        input logic [CH_WIDTH-1:0] x,
        input logic [3:0]          ctrl,
        input logic [CH_WIDTH-1:0] thresh,
        input logic [CH_WIDTH:0]   offset
    );
        logic [CH_WIDTH+1:0] sum;
        logic [CH_WIDTH-1:0] y;
        y   = x;
        // Two guard bits: top bit flags underflow, next flags overflow.
        sum = {2'b00, x} + {offset[CH_WIDTH], offset};
        if (ctrl[0]) begin
            if (sum[CH_WIDTH+1])   y = '0;
            else if (sum[CH_WIDTH]) y = '1;
            else                    y = sum[CH_WIDTH-1:0];
        end
        if (ctrl[1]) y = ~y;
        if (ctrl[2]) y = (y >= thresh) ? '1 : '0;
        if (ctrl[3]) y = x;
        return y;
    endfunction

    // First beat of a frame sees the shadow directly so the whole frame uses one config.
    assign cfg_ctrl   = in_frame ? ctrl_act   : ctrl_sh;
    assign cfg_thresh = in_frame ? thresh_act : thresh_sh;
    assign cfg_offset = in_frame ? offset_act : offset_sh;

    always_comb begin
        proc_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            proc_data[k*CH_WIDTH +: CH_WIDTH] =
                point_op(s_axis_data[k*CH_WIDTH +: CH_WIDTH], cfg_ctrl, cfg_thresh, cfg_offset);
        end
    end

    assign s_axis_ready = !m_axis_valid || m_axis_ready;
    assign s_fire       = s_axis_valid && s_axis_ready;
    assign m_fire       = m_axis_valid && m_axis_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            m_axis_data  <= '0;
            m_axis_keep  <= '0;
        end else if (s_fire) begin
            m_axis_valid <= 1'b1;
            m_axis_last  <= s_axis_last;
            m_axis_data  <= proc_data;
            m_axis_keep  <= s_axis_keep;
        end else if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
        end
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            in_frame   <= 1'b0;
            ctrl_act   <= '0;
            thresh_act <= '0;
            offset_act <= '0;
        end else begin
            if (s_fire) in_frame <= !s_axis_last;
            if (!in_frame) begin
                ctrl_act   <= ctrl_sh;
                thresh_act <= thresh_sh;
                offset_act <= offset_sh;
            end
        end
    end

    // ------------------------------------------------------------------
    // AXI4-Lite slave
    // ------------------------------------------------------------------
    assign wr_idx  = s_axi_awaddr[4:2];
    assign rd_idx  = s_axi_araddr[4:2];
    assign wmask   = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                      {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
    assign wr_fire = (state == IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign rd_fire = (state == IDLE) && s_axi_arvalid && !(s_axi_awvalid && s_axi_wvalid);

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) state <= IDLE;
        else           state <= state_next;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next    = state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_rvalid  = 1'b0;
        unique case (state)
            IDLE: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                s_axi_arready = 1'b1;
                if (wr_fire)      state_next = WRESP;
                else if (rd_fire) state_next = RRESP;
            end
            WRESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) state_next = IDLE;
            end
            RRESP: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            ctrl_sh   <= '0;
            thresh_sh <= '0;
            offset_sh <= '0;
        end else if (wr_fire) begin
            case (wr_idx)
                3'd0: ctrl_sh   <= (ctrl_sh & ~wmask[3:0]) | (s_axi_wdata[3:0] & wmask[3:0]);
                3'd1: thresh_sh <= (thresh_sh & ~wmask[CH_WIDTH-1:0])
                                 | (s_axi_wdata[CH_WIDTH-1:0] & wmask[CH_WIDTH-1:0]);
                3'd2: offset_sh <= (offset_sh & ~wmask[CH_WIDTH:0])
                                 | (s_axi_wdata[CH_WIDTH:0] & wmask[CH_WIDTH:0]);
                default: ;
            endcase
        end
    end

`ifdef PIXEL_POINT_OP_STATS_EN
    logic [31:0] beat_cnt, frame_cnt;
    logic        stats_clr;

    assign stats_clr = wr_fire && ((wr_idx == 3'd3) || (wr_idx == 3'd4));

    // A clear wins over a coincident output handshake.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else if (stats_clr) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else if (m_fire) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (m_axis_last) frame_cnt <= frame_cnt + 32'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = m_fire;
`endif

    always_comb begin
        rd_val = '0;
        case (rd_idx)
            3'd0: rd_val[3:0]          = ctrl_sh;
            3'd1: rd_val[CH_WIDTH-1:0] = thresh_sh;
            3'd2: rd_val[CH_WIDTH:0]   = offset_sh;
`ifdef PIXEL_POINT_OP_STATS_EN
            3'd3: rd_val = beat_cnt;
            3'd4: rd_val = frame_cnt;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset)    s_axi_rdata <= '0;
        else if (rd_fire) s_axi_rdata <= rd_val;
    end

    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                           s_axi_wdata[31:CH_WIDTH+1], wmask[31:CH_WIDTH+1]};

endmodule
